// File: rtl/ball_pixel_if.sv
// Ball position and VGA pixel stream bundle between the source side and the ball renderer.
// The source drives sync, ball coordinates and pixel positions; the renderer returns flags and area.
interface ball_pixel_if;
    logic        VGA_VS;
    logic [9:0]  BallX;
    logic [9:0]  BallY;
    logic [9:0]  BallS;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        pix_valid;
    logic        ball_on;
    logic        ball_rim;
    logic        pix_valid_o;
    logic [17:0] ball_area;

    modport master (
        output VGA_VS, BallX, BallY, BallS, DrawX, DrawY, pix_valid,
        input  ball_on, ball_rim, pix_valid_o, ball_area
    );

    modport slave (
        input  VGA_VS, BallX, BallY, BallS, DrawX, DrawY, pix_valid,
        output ball_on, ball_rim, pix_valid_o, ball_area
    );
endinterface

// File: rtl/ball_pixel_renderer.sv
// Two-stage pixel pipeline producing ball/rim flags against a ball position latched once per frame,
// plus a saturating count of ball pixels reported for the previous frame.
module ball_pixel_renderer #(
    parameter int RIM_W = 2,
    parameter int RST_X = 320,
    parameter int RST_Y = 240,
    parameter int RST_S = 10
) (
    input  logic         Clk,
    input  logic         Reset,
    ball_pixel_if.slave  bus
);

    localparam logic [9:0]  L_RST_X = 10'(RST_X);
    localparam logic [9:0]  L_RST_Y = 10'(RST_Y);
    localparam logic [9:0]  L_RST_S = 10'(RST_S);
    localparam logic [9:0]  L_RIM_W = 10'(RIM_W);
    localparam logic [17:0] L_ACC_MAX = 18'h3FFFF;

    logic               r_vs_d;
    logic [9:0]         r_bx;
    logic [9:0]         r_by;
    logic [9:0]         r_bs;
    logic signed [10:0] r_dx;
    logic signed [10:0] r_dy;
    logic [9:0]         r_s1;
    logic               r_v1;
    logic               r_ball_on;
    logic               r_ball_rim;
    logic               r_pix_valid_o;
    logic [17:0]        r_area;
    logic [17:0]        r_acc;

    logic               w_frame_start;
    logic signed [21:0] w_dx_ext;
    logic signed [21:0] w_dy_ext;
    logic signed [21:0] w_dx_sq;
    logic signed [21:0] w_dy_sq;
    logic [21:0]        w_d2;
    logic [19:0]        w_s_ext;
    logic [19:0]        w_s_sq;
    logic [19:0]        w_in_ext;
    logic [19:0]        w_in_sq;
    logic               w_on_next;
    logic               w_rim_next;

    // Falling edge of active-low vsync marks the start of a new frame
    assign w_frame_start = r_vs_d & ~bus.VGA_VS;

    // Stage-2 squared distance and inside/rim decisions
    always_comb begin
        w_dx_ext   = {{11{r_dx[10]}}, r_dx};
        w_dy_ext   = {{11{r_dy[10]}}, r_dy};
        w_dx_sq    = w_dx_ext * w_dx_ext;
        w_dy_sq    = w_dy_ext * w_dy_ext;
        w_d2       = $unsigned(w_dx_sq) + $unsigned(w_dy_sq);
        w_s_ext    = {10'd0, r_s1};
        w_s_sq     = w_s_ext * w_s_ext;
        w_in_ext   = {10'd0, r_s1 - L_RIM_W};
        w_in_sq    = w_in_ext * w_in_ext;
        w_on_next  = r_v1 & (r_s1 != 10'd0) & (w_d2 <= {2'b00, w_s_sq});
        // A radius no wider than the rim is rim all the way through
        if (r_s1 <= L_RIM_W) begin
            w_rim_next = w_on_next;
        end else begin
            w_rim_next = w_on_next & (w_d2 > {2'b00, w_in_sq});
        end
    end

    // Frame latch, two-stage pixel pipeline and area accumulation
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vs_d        <= 1'b1;
            r_bx          <= L_RST_X;
            r_by          <= L_RST_Y;
            r_bs          <= L_RST_S;
            r_dx          <= 11'sd0;
            r_dy          <= 11'sd0;
            r_s1          <= 10'd0;
            r_v1          <= 1'b0;
            r_ball_on     <= 1'b0;
            r_ball_rim    <= 1'b0;
            r_pix_valid_o <= 1'b0;
            r_area        <= 18'd0;
            r_acc         <= 18'd0;
        end else begin
            r_vs_d <= bus.VGA_VS;
            // A ball pixel leaving the pipe on the frame edge belongs to the new frame
            if (w_frame_start) begin
                r_bx   <= bus.BallX;
                r_by   <= bus.BallY;
                r_bs   <= bus.BallS;
                r_area <= r_acc;
                r_acc  <= r_ball_on ? 18'd1 : 18'd0;
            end else if (r_ball_on && (r_acc != L_ACC_MAX)) begin
                r_acc  <= r_acc + 18'd1;
            end
            r_dx          <= $signed({1'b0, bus.DrawX}) - $signed({1'b0, r_bx});
            r_dy          <= $signed({1'b0, bus.DrawY}) - $signed({1'b0, r_by});
            r_s1          <= r_bs;
            r_v1          <= bus.pix_valid;
            r_ball_on     <= w_on_next;
            r_ball_rim    <= w_rim_next;
            r_pix_valid_o <= r_v1;
        end
    end

    assign bus.ball_on     = r_ball_on;
    assign bus.ball_rim    = r_ball_rim;
    assign bus.pix_valid_o = r_pix_valid_o;
    assign bus.ball_area   = r_area;

endmodule

// File: tb/tb_ball_pixel_renderer.sv
// Scoreboard bench for ball_pixel_renderer: expected flags are queued as pixels are driven
// and compared two clocks later; frame area is tracked by a reference accumulator.
module tb_ball_pixel_renderer;

    logic clk;
    logic rst;
    ball_pixel_if bus ();

    ball_pixel_renderer dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp;
    int         n_err;
    logic [2:0] exp_q[$];
    int         m_bx, m_by, m_bs;
    logic       m_vs_d;
    logic       m_last_on;
    int         m_acc;
    int         m_area;
    int         golden;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {on, rim} for a pixel against a ball centre/radius
    function automatic logic [1:0] model_pix(input int x, input int y, input int bx, input int by, input int bs);
        int   d2;
        logic on;
        logic rim;
        d2  = (x - bx) * (x - bx) + (y - by) * (y - by);
        on  = (bs != 0) && (d2 <= bs * bs);
        rim = on && ((bs <= 2) || (d2 > (bs - 2) * (bs - 2)));
        return {on, rim};
    endfunction

    task automatic cycle(input logic vs, input int x, input int y, input logic v);
        logic       fs;
        logic [1:0] e;
        logic [2:0] item;
        bus.VGA_VS    = vs;
        bus.DrawX     = 10'(x);
        bus.DrawY     = 10'(y);
        bus.pix_valid = v;
        fs = m_vs_d & ~vs;
        e  = model_pix(x, y, m_bx, m_by, m_bs);
        exp_q.push_back({v, v & e[1], v & e[0]});
        if (fs) begin
            m_area = m_acc;
            m_acc  = m_last_on ? 1 : 0;
            m_bx   = int'(bus.BallX);
            m_by   = int'(bus.BallY);
            m_bs   = int'(bus.BallS);
        end else if (m_last_on && (m_acc < 262143)) begin
            m_acc++;
        end
        m_vs_d = vs;
        @(posedge clk);
        #1;
        if (exp_q.size() == 2) begin
            item = exp_q.pop_front();
            check_eq("pix_valid_o", 32'(bus.pix_valid_o), 32'(item[2]));
            check_eq("ball_on", 32'(bus.ball_on), 32'(item[1]));
            check_eq("ball_rim", 32'(bus.ball_rim), 32'(item[0]));
            m_last_on = item[1];
        end
        if (fs) check_eq("ball_area", 32'(bus.ball_area), 32'(m_area));
    endtask

    task automatic px(input int x, input int y);
        cycle(1'b1, x, y, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 0, 0, 1'b0);
    endtask

    task automatic vsync();
        cycle(1'b1, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.VGA_VS    = 1'b1;
        bus.pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_bx      = 320;
        m_by      = 240;
        m_bs      = 10;
        m_vs_d    = 1'b1;
        m_last_on = 1'b0;
        m_acc     = 0;
        m_area    = 0;
        check_eq("rst_on", 32'(bus.ball_on), 32'd0);
        check_eq("rst_rim", 32'(bus.ball_rim), 32'd0);
        check_eq("rst_valid_o", 32'(bus.pix_valid_o), 32'd0);
        check_eq("rst_area", 32'(bus.ball_area), 32'd0);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                cycle(1'b1, x, y, !((x == x0 + 2) && (y == y0 + 3)));
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        bus.BallX = 10'd320;
        bus.BallY = 10'd240;
        bus.BallS = 10'd10;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.VGA_VS = 1'b1;
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        vsync();
        px(320, 240);
        px(330, 240);
        px(331, 240);
        px(327, 247);
        px(329, 240);
        px(322, 240);
        px(310, 240);
        px(320, 251);
        idle(2);

        bus.BallX = 10'd100;
        px(320, 240);
        cycle(1'b1, 0, 0, 1'b0);
        cycle(1'b0, 320, 240, 1'b1);
        px(320, 240);
        px(100, 240);
        px(110, 240);
        idle(2);

        bus.BallS = 10'd0;
        vsync();
        scan(90, 110, 230, 250);
        idle(2);
        bus.BallX = 10'd5;
        bus.BallY = 10'd5;
        bus.BallS = 10'd10;
        vsync();
        scan(0, 20, 0, 20);
        scan(625, 639, 0, 15);
        idle(2);
        vsync();

        golden = 0;
        for (int y = 0; y <= 20; y++) begin
            for (int x = 0; x <= 20; x++) begin
                if ((x - 5) * (x - 5) + (y - 5) * (y - 5) <= 100 && !((x == 2) && (y == 3))) golden++;
            end
        end
        check_eq("area_golden", 32'(bus.ball_area), 32'(golden));

        px(5, 5);
        px(0, 0);
        cycle(1'b1, 3, 5, 1'b0);
        px(15, 5);
        px(16, 5);
        do_reset();
        vsync();
        px(320, 240);
        px(330, 240);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
